// File: rtl/proto_tx_scheduler_if.sv
// proto_tx_scheduler_if: requester-side and line-side signals of the tx scheduler
interface proto_tx_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 32,
  parameter int CNT_W = 26,
  parameter int ID_W = 2
);
  logic en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ*CNT_W-1:0] div_cfg;
  logic [NUM_REQ-1:0] gnt;
  logic busy;
  logic [ID_W-1:0] active_id;
  logic tx_out;
  logic done;
  logic [ID_W-1:0] done_id;
  modport master (output en, req, data_in, div_cfg, input gnt, busy, active_id, tx_out, done, done_id);
  modport slave (input en, req, data_in, div_cfg, output gnt, busy, active_id, tx_out, done, done_id);
endinterface

// File: rtl/proto_tx_scheduler.sv
// proto_tx_scheduler: round-robin arbiter and LSB-first serializer for a shared tx line
module proto_tx_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 32,
  parameter int CNT_W = 26,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic reset,
  proto_tx_scheduler_if.slave bus
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [ID_W-1:0] rr_last;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0] bitn;
  logic [DATA_W-1:0] win_data;
  logic [CNT_W-1:0] win_div;
  logic [ID_W-1:0] win_id;
  logic [NUM_REQ-1:0] win_gnt;
  int d;
  int best;
  // winner is the asserted requester closest after rr_last in circular order
  always_comb begin
    win_data = '0;
    win_div = '0;
    win_id = '0;
    win_gnt = '0;
    best = NUM_REQ;
    d = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(rr_last)) % NUM_REQ;
      if (bus.req[i] && d < best) begin
        best = d;
        win_data = bus.data_in[i*DATA_W +: DATA_W];
        win_div = bus.div_cfg[i*CNT_W +: CNT_W];
        win_id = ID_W'(i);
        win_gnt = NUM_REQ'(1) << i;
      end
    end
  end
  // grant in IDLE, then hold each bit for div_r+1 cycles and pulse done after the last
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rr_last <= ID_W'(NUM_REQ - 1);
      shreg <= '0;
      div_r <= '0;
      cnt <= '0;
      bitn <= '0;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
      bus.active_id <= '0;
      bus.tx_out <= 1'b1;
      bus.done <= 1'b0;
      bus.done_id <= '0;
    end else begin
      bus.gnt <= '0;
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.en && |bus.req) begin
          state <= SHIFT;
          bus.gnt <= win_gnt;
          bus.busy <= 1'b1;
          bus.active_id <= win_id;
          rr_last <= win_id;
          shreg <= win_data;
          div_r <= win_div;
          bus.tx_out <= win_data[0];
          cnt <= '0;
          bitn <= '0;
        end
      end else if (cnt != div_r) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (bitn != BW'(DATA_W - 1)) begin
          bitn <= bitn + 1'b1;
          shreg <= shreg >> 1;
          bus.tx_out <= shreg[1];
        end else begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.tx_out <= 1'b1;
          bus.done <= 1'b1;
          bus.done_id <= bus.active_id;
        end
      end
    end
endmodule
